// File: rtl/rob_commit.sv
// Retire stage: pops up to two completed ROB heads in order, serialises stores, sequences flushes.
// Latency: rd_en1/rd_en2 combinational; commit records, store_req and rob_flush registered (+1 cycle).
// Backpressure: commit_stall blocks pops; a head store waits for store_ack; a flush blocks pops for FLUSH_CYCLES.
module rob_commit #(
  parameter int DATA_WIDTH   = 124,
  parameter int FLUSH_CYCLES = 4,
  parameter int CNT_WIDTH    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  head0_valid,
  input  logic [DATA_WIDTH-1:0] head0_data,
  input  logic                  head0_done,
  input  logic                  head0_is_store,
  input  logic                  head1_valid,
  input  logic [DATA_WIDTH-1:0] head1_data,
  input  logic                  head1_done,
  input  logic                  head1_is_store,
  output logic                  rd_en1,
  output logic                  rd_en2,
  output logic                  store_req,
  input  logic                  store_ack,
  input  logic                  commit_stall,
  input  logic                  flush_req,
  output logic                  rob_flush,
  output logic                  commit0_valid,
  output logic [63:0]           commit0_pc,
  output logic [4:0]            commit0_lrd,
  output logic [5:0]            commit0_prd,
  output logic [5:0]            commit0_old_prd,
  output logic                  commit0_need_to_wb,
  output logic                  commit1_valid,
  output logic [63:0]           commit1_pc,
  output logic [4:0]            commit1_lrd,
  output logic [5:0]            commit1_prd,
  output logic [5:0]            commit1_old_prd,
  output logic                  commit1_need_to_wb,
  output logic [CNT_WIDTH-1:0]  retired_count
);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_STORE_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH      = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [3:0]           fcnt_q, fcnt_d;
  logic                 store_req_q, store_req_d;
  logic                 rob_flush_q, rob_flush_d;
  logic [CNT_WIDTH-1:0] retired_count_q, retired_count_d;

  logic                 c0, c1, st_ret;
  logic                 pop0, pop1;

  logic                 commit0_valid_q, commit0_valid_d;
  logic [63:0]          commit0_pc_q, commit0_pc_d;
  logic [4:0]           commit0_lrd_q, commit0_lrd_d;
  logic [5:0]           commit0_prd_q, commit0_prd_d;
  logic [5:0]           commit0_old_prd_q, commit0_old_prd_d;
  logic                 commit0_nwb_q, commit0_nwb_d;
  logic                 commit1_valid_q, commit1_valid_d;
  logic [63:0]          commit1_pc_q, commit1_pc_d;
  logic [4:0]           commit1_lrd_q, commit1_lrd_d;
  logic [5:0]           commit1_prd_q, commit1_prd_d;
  logic [5:0]           commit1_old_prd_q, commit1_old_prd_d;
  logic                 commit1_nwb_q, commit1_nwb_d;

  // instr and source-register fields are not needed at retire
  logic unused_payload;
  assign unused_payload = ^{head0_data[59:18], head1_data[59:18]};

  // Retire decision and FSM next state; a flush request overrides everything else
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    store_req_d = store_req_q;
    rob_flush_d = rob_flush_q;
    c0          = 1'b0;
    c1          = 1'b0;
    st_ret      = 1'b0;
    if (flush_req) begin
      state_d     = ST_FLUSH;
      fcnt_d      = 4'(FLUSH_CYCLES);
      store_req_d = 1'b0;
      rob_flush_d = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!commit_stall && head0_valid && head0_done) begin
            if (head0_is_store) begin
              // stores retire alone from slot 0 after the store buffer takes them
              store_req_d = 1'b1;
              state_d     = ST_STORE_WAIT;
            end else begin
              c0 = 1'b1;
              c1 = head1_valid && head1_done && !head1_is_store;
            end
          end
        end
        ST_STORE_WAIT: begin
          if (store_ack) begin
            st_ret      = 1'b1;
            store_req_d = 1'b0;
            state_d     = ST_RUN;
          end
        end
        ST_FLUSH: begin
          // counter holds the remaining high cycles of rob_flush including this one
          if (fcnt_q <= 4'd1) begin
            fcnt_d      = 4'd0;
            rob_flush_d = 1'b0;
            state_d     = ST_RUN;
          end else begin
            fcnt_d = fcnt_q - 4'd1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Pop enables, commit record capture and retired counter update
  always_comb begin
    pop0              = !reset && (c0 || st_ret);
    pop1              = !reset && c1;
    commit0_valid_d   = pop0;
    commit0_pc_d      = head0_data[123:60];
    commit0_lrd_d     = head0_data[17:13];
    commit0_prd_d     = head0_data[12:7];
    commit0_old_prd_d = head0_data[6:1];
    commit0_nwb_d     = head0_data[0];
    commit1_valid_d   = pop1;
    commit1_pc_d      = head1_data[123:60];
    commit1_lrd_d     = head1_data[17:13];
    commit1_prd_d     = head1_data[12:7];
    commit1_old_prd_d = head1_data[6:1];
    commit1_nwb_d     = head1_data[0];
    retired_count_d   = retired_count_q + CNT_WIDTH'(pop0) + CNT_WIDTH'(pop1);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_RUN;
      fcnt_q            <= 4'd0;
      store_req_q       <= 1'b0;
      rob_flush_q       <= 1'b0;
      retired_count_q   <= '0;
      commit0_valid_q   <= 1'b0;
      commit0_pc_q      <= '0;
      commit0_lrd_q     <= '0;
      commit0_prd_q     <= '0;
      commit0_old_prd_q <= '0;
      commit0_nwb_q     <= 1'b0;
      commit1_valid_q   <= 1'b0;
      commit1_pc_q      <= '0;
      commit1_lrd_q     <= '0;
      commit1_prd_q     <= '0;
      commit1_old_prd_q <= '0;
      commit1_nwb_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      fcnt_q            <= fcnt_d;
      store_req_q       <= store_req_d;
      rob_flush_q       <= rob_flush_d;
      retired_count_q   <= retired_count_d;
      commit0_valid_q   <= commit0_valid_d;
      commit0_pc_q      <= commit0_pc_d;
      commit0_lrd_q     <= commit0_lrd_d;
      commit0_prd_q     <= commit0_prd_d;
      commit0_old_prd_q <= commit0_old_prd_d;
      commit0_nwb_q     <= commit0_nwb_d;
      commit1_valid_q   <= commit1_valid_d;
      commit1_pc_q      <= commit1_pc_d;
      commit1_lrd_q     <= commit1_lrd_d;
      commit1_prd_q     <= commit1_prd_d;
      commit1_old_prd_q <= commit1_old_prd_d;
      commit1_nwb_q     <= commit1_nwb_d;
    end
  end

  assign rd_en1             = pop0;
  assign rd_en2             = pop1;
  assign store_req          = store_req_q;
  assign rob_flush          = rob_flush_q;
  assign retired_count      = retired_count_q;
  assign commit0_valid      = commit0_valid_q;
  assign commit0_pc         = commit0_pc_q;
  assign commit0_lrd        = commit0_lrd_q;
  assign commit0_prd        = commit0_prd_q;
  assign commit0_old_prd    = commit0_old_prd_q;
  assign commit0_need_to_wb = commit0_nwb_q;
  assign commit1_valid      = commit1_valid_q;
  assign commit1_pc         = commit1_pc_q;
  assign commit1_lrd        = commit1_lrd_q;
  assign commit1_prd        = commit1_prd_q;
  assign commit1_old_prd    = commit1_old_prd_q;
  assign commit1_need_to_wb = commit1_nwb_q;

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: expected commit records queued at drive time, checked on output.
// A second instance with a 2-bit counter shares all inputs to exercise counter wrap.
module tb_rob_commit;

  logic         clk = 1'b0;
  logic         reset;
  logic         head0_valid, head0_done, head0_is_store;
  logic         head1_valid, head1_done, head1_is_store;
  logic [123:0] head0_data, head1_data;
  logic         store_ack, commit_stall, flush_req;
  logic         rd_en1, rd_en2, store_req, rob_flush;
  logic         commit0_valid, commit0_need_to_wb, commit1_valid, commit1_need_to_wb;
  logic [63:0]  commit0_pc, commit1_pc;
  logic [4:0]   commit0_lrd, commit1_lrd;
  logic [5:0]   commit0_prd, commit0_old_prd, commit1_prd, commit1_old_prd;
  logic [63:0]  retired_count;

  logic         b_unused_rd1, b_unused_rd2, b_unused_sreq, b_unused_flush;
  logic         b_unused_v0, b_unused_w0, b_unused_v1, b_unused_w1;
  logic [63:0]  b_unused_pc0, b_unused_pc1;
  logic [4:0]   b_unused_l0, b_unused_l1;
  logic [5:0]   b_unused_p0, b_unused_o0, b_unused_p1, b_unused_o1;
  logic [1:0]   cnt_b;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  lrd;
    logic [5:0]  prd;
    logic [5:0]  oprd;
    logic        nwb;
  } rec_t;

  rec_t        exp_q[$];
  logic [63:0] exp_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  rob_commit #(.DATA_WIDTH(124), .FLUSH_CYCLES(4), .CNT_WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .head0_valid(head0_valid), .head0_data(head0_data), .head0_done(head0_done), .head0_is_store(head0_is_store),
    .head1_valid(head1_valid), .head1_data(head1_data), .head1_done(head1_done), .head1_is_store(head1_is_store),
    .rd_en1(rd_en1), .rd_en2(rd_en2), .store_req(store_req), .store_ack(store_ack),
    .commit_stall(commit_stall), .flush_req(flush_req), .rob_flush(rob_flush),
    .commit0_valid(commit0_valid), .commit0_pc(commit0_pc), .commit0_lrd(commit0_lrd),
    .commit0_prd(commit0_prd), .commit0_old_prd(commit0_old_prd), .commit0_need_to_wb(commit0_need_to_wb),
    .commit1_valid(commit1_valid), .commit1_pc(commit1_pc), .commit1_lrd(commit1_lrd),
    .commit1_prd(commit1_prd), .commit1_old_prd(commit1_old_prd), .commit1_need_to_wb(commit1_need_to_wb),
    .retired_count(retired_count)
  );

  rob_commit #(.DATA_WIDTH(124), .FLUSH_CYCLES(4), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset),
    .head0_valid(head0_valid), .head0_data(head0_data), .head0_done(head0_done), .head0_is_store(head0_is_store),
    .head1_valid(head1_valid), .head1_data(head1_data), .head1_done(head1_done), .head1_is_store(head1_is_store),
    .rd_en1(b_unused_rd1), .rd_en2(b_unused_rd2), .store_req(b_unused_sreq), .store_ack(store_ack),
    .commit_stall(commit_stall), .flush_req(flush_req), .rob_flush(b_unused_flush),
    .commit0_valid(b_unused_v0), .commit0_pc(b_unused_pc0), .commit0_lrd(b_unused_l0),
    .commit0_prd(b_unused_p0), .commit0_old_prd(b_unused_o0), .commit0_need_to_wb(b_unused_w0),
    .commit1_valid(b_unused_v1), .commit1_pc(b_unused_pc1), .commit1_lrd(b_unused_l1),
    .commit1_prd(b_unused_p1), .commit1_old_prd(b_unused_o1), .commit1_need_to_wb(b_unused_w1),
    .retired_count(cnt_b)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected retire record derived from the PC alone
  function automatic rec_t mk_rec(input logic [63:0] pc);
    rec_t r;
    r.pc   = pc;
    r.lrd  = pc[6:2];
    r.prd  = pc[8:3] ^ 6'h2a;
    r.oprd = pc[9:4] ^ 6'h15;
    r.nwb  = pc[2];
    return r;
  endfunction

  function automatic logic [123:0] mk_data(input logic [63:0] pc);
    rec_t r;
    r = mk_rec(pc);
    return {r.pc, 32'hdead_beef, 5'd3, 5'd7, r.lrd, r.prd, r.oprd, r.nwb};
  endfunction

  task automatic set_heads(input logic v0, input logic [63:0] pc0, input logic d0, input logic s0,
                           input logic v1, input logic [63:0] pc1, input logic d1, input logic s1);
    head0_valid = v0; head0_data = mk_data(pc0); head0_done = d0; head0_is_store = s0;
    head1_valid = v1; head1_data = mk_data(pc1); head1_done = d1; head1_is_store = s1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pop(input logic [63:0] pc);
    exp_q.push_back(mk_rec(pc));
    exp_cnt = exp_cnt + 64'd1;
  endtask

  // Scoreboard: every registered commit record must match the oldest queued expectation
  always @(posedge clk) begin
    #1;
    if (commit0_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("commit0_unexpected", 128'(1), 128'(0));
      else chk("commit0_record", 128'({commit0_pc, commit0_lrd, commit0_prd, commit0_old_prd, commit0_need_to_wb}),
               128'(exp_q.pop_front()));
    end
    if (commit1_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("commit1_unexpected", 128'(1), 128'(0));
      else chk("commit1_record", 128'({commit1_pc, commit1_lrd, commit1_prd, commit1_old_prd, commit1_need_to_wb}),
               128'(exp_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; store_ack = 1'b0; commit_stall = 1'b0; flush_req = 1'b0;
    set_heads(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    exp_cnt = 64'd0;
    tick(); tick();
    chk("rst_rd_en", 128'({rd_en1, rd_en2}), 128'(0));
    chk("rst_store_req", 128'(store_req), 128'(0));
    chk("rst_rob_flush", 128'(rob_flush), 128'(0));
    chk("rst_commit_valid", 128'({commit0_valid, commit1_valid}), 128'(0));
    chk("rst_count", 128'(retired_count), 128'(0));
    reset = 1'b0;
    tick();

    // Dual retire
    set_heads(1'b1, 64'h1000, 1'b1, 1'b0, 1'b1, 64'h1004, 1'b1, 1'b0);
    #1 chk("dual_rd_en", 128'({rd_en1, rd_en2}), 128'(2'b11));
    expect_pop(64'h1000); expect_pop(64'h1004);
    tick();
    chk("dual_count", 128'(retired_count), 128'(exp_cnt));

    // Slot 0 only, then head0 not done blocks slot 1
    set_heads(1'b1, 64'h2000, 1'b1, 1'b0, 1'b1, 64'h2004, 1'b0, 1'b0);
    #1 chk("single_rd_en", 128'({rd_en1, rd_en2}), 128'(2'b10));
    expect_pop(64'h2000);
    tick();
    chk("single_commit1_valid", 128'(commit1_valid), 128'(0));
    set_heads(1'b1, 64'h2004, 1'b0, 1'b0, 1'b1, 64'h2008, 1'b1, 1'b0);
    #1 chk("blocked_rd_en", 128'({rd_en1, rd_en2}), 128'(0));
    tick();
    chk("blocked_count", 128'(retired_count), 128'(exp_cnt));

    // Stalled store at head: no request, stray ack ignored
    set_heads(1'b1, 64'h3000, 1'b1, 1'b1, 1'b1, 64'h3004, 1'b1, 1'b0);
    commit_stall = 1'b1; store_ack = 1'b1;
    #1 chk("stall_store_rd_en", 128'({rd_en1, rd_en2}), 128'(0));
    tick();
    chk("stall_store_req", 128'(store_req), 128'(0));
    commit_stall = 1'b0; store_ack = 1'b0;
    #1 chk("store_decide_rd_en", 128'({rd_en1, rd_en2}), 128'(0));
    tick();
    chk("store_req_rise", 128'(store_req), 128'(1));
    for (int i = 0; i < 2; i++) begin
      #1 chk("store_wait_rd_en", 128'({rd_en1, rd_en2}), 128'(0));
      tick();
      chk("store_req_held", 128'(store_req), 128'(1));
    end
    store_ack = 1'b1;
    #1 chk("store_ack_rd_en", 128'({rd_en1, rd_en2}), 128'(2'b10));
    expect_pop(64'h3000);
    tick();
    store_ack = 1'b0;
    chk("store_req_fall", 128'(store_req), 128'(0));
    chk("store_count", 128'(retired_count), 128'(exp_cnt));
    chk("wrap_count_a", 128'(cnt_b), 128'(exp_cnt[1:0]));
    set_heads(1'b1, 64'h3004, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    #1 chk("post_store_rd_en", 128'({rd_en1, rd_en2}), 128'(2'b10));
    expect_pop(64'h3004);
    tick();

    // Flush during STORE_WAIT
    set_heads(1'b1, 64'h4000, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    tick();
    chk("flush_store_req_pre", 128'(store_req), 128'(1));
    flush_req = 1'b1; store_ack = 1'b1;
    #1 chk("flush_req_rd_en", 128'({rd_en1, rd_en2}), 128'(0));
    tick();
    flush_req = 1'b0; store_ack = 1'b0;
    set_heads(1'b1, 64'h5000, 1'b1, 1'b0, 1'b1, 64'h5004, 1'b1, 1'b0);
    chk("flush_store_req_drop", 128'(store_req), 128'(0));
    n = 0;
    while (rob_flush === 1'b1 && n < 10) begin
      #1 chk("flush_rd_en", 128'({rd_en1, rd_en2}), 128'(0));
      tick();
      n++;
    end
    chk("flush_length", 128'(n), 128'(4));
    #1 chk("post_flush_rd_en", 128'({rd_en1, rd_en2}), 128'(2'b11));
    expect_pop(64'h5000); expect_pop(64'h5004);
    tick();

    // External stall for 5 cycles then release
    set_heads(1'b1, 64'h6000, 1'b1, 1'b0, 1'b1, 64'h6004, 1'b1, 1'b0);
    commit_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall_rd_en", 128'({rd_en1, rd_en2}), 128'(0));
      tick();
    end
    commit_stall = 1'b0;
    #1 chk("release_rd_en", 128'({rd_en1, rd_en2}), 128'(2'b11));
    expect_pop(64'h6000); expect_pop(64'h6004);
    tick();
    chk("release_count", 128'(retired_count), 128'(exp_cnt));
    chk("wrap_count_b", 128'(cnt_b), 128'(exp_cnt[1:0]));

    // Reset in the middle of a flush
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    chk("mid_flush_rob_flush", 128'(rob_flush), 128'(1));
    reset = 1'b1;
    #1 chk("reset_rd_en", 128'({rd_en1, rd_en2}), 128'(0));
    tick();
    exp_cnt = 64'd0;
    chk("reset_rob_flush", 128'(rob_flush), 128'(0));
    chk("reset_store_req", 128'(store_req), 128'(0));
    chk("reset_commit_valid", 128'({commit0_valid, commit1_valid}), 128'(0));
    chk("reset_count", 128'(retired_count), 128'(0));
    reset = 1'b0;
    #1 chk("after_reset_rd_en", 128'({rd_en1, rd_en2}), 128'(2'b11));
    expect_pop(64'h6000); expect_pop(64'h6004);
    tick();
    set_heads(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("final_count", 128'(retired_count), 128'(exp_cnt));
    tick();
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
# rob_commit

Retire stage sitting at the read end of the reorder buffer queue. Inspects the two oldest ROB entries each cycle and pops up to two completed instructions in program order via the queue's two read enables. Publishes registered commit records to the rename map and free list. Serialises stores through a request/acknowledge handshake with the store buffer, and runs a fixed-length pipeline flush sequence on request.

## Interface
- DATA_WIDTH, 124, ROB entry payload: pc[123:60], instr[59:28], lrs1[27:23], lrs2[22:18], lrd[17:13], prd[12:7], old_prd[6:1], need_to_wb[0]
- FLUSH_CYCLES, 4, cycles rob_flush is held high per flush (1..15)
- CNT_WIDTH, 64, retired-instruction counter width
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- head0_valid  in  1  oldest ROB entry present
- head0_data  in  DATA_WIDTH  oldest entry payload
- head0_done  in  1  oldest entry status (completed)
- head0_is_store  in  1  oldest entry is a store
- head1_valid, head1_data, head1_done, head1_is_store  in  1/DATA_WIDTH/1/1  second-oldest entry, same meanings
- rd_en1  out  1  pop oldest entry this cycle (combinational)
- rd_en2  out  1  pop second-oldest entry this cycle (combinational)
- store_req  out  1  request store buffer to drain the head store (registered)
- store_ack  in  1  store buffer accepted head store
- commit_stall  in  1  external hold; no retirement while high
- flush_req  in  1  one-cycle pulse: squash the pipeline
- rob_flush  out  1  flush broadcast to ROB and front end (registered)
- commitN_valid  out  1  N=0,1; commit record valid (registered)
- commitN_pc  out  64  retired PC
- commitN_lrd, commitN_prd, commitN_old_prd, commitN_need_to_wb  out  5/6/6/1  rename-map update and free-list release (old_prd freed when need_to_wb)
- retired_count  out  CNT_WIDTH  total retired instructions

## Operation
- States: RUN, STORE_WAIT, FLUSH. Reset → RUN.
- c0 (slot-0 commit, RUN): state==RUN && !flush_req && !commit_stall && head0_valid && head0_done && !head0_is_store.
- c1 (RUN): c0 && head1_valid && head1_done && !head1_is_store.
- Slot 1 never retires without slot 0; stores retire only from slot 0.
- RUN, head0 valid+done+is_store, !commit_stall, !flush_req → set store_req, go STORE_WAIT; no pops that cycle.
- STORE_WAIT: store_req held high until store_ack. If store_ack && !flush_req: rd_en1=1 (store retires alone, rd_en2=0), clear store_req, return to RUN. Store_ack ignored outside STORE_WAIT.
- flush_req (any state) has top priority: rd_en1=rd_en2=0 that cycle; clear store_req; load counter with FLUSH_CYCLES; go FLUSH.
- FLUSH: rob_flush=1; counter decrements each cycle; return to RUN after FLUSH_CYCLES cycles. flush_req during FLUSH reloads the counter.
- rd_en1 = c0 | store retire; rd_en2 = c1.
- retired_count += rd_en1 + rd_en2 (0/1/2); wraps modulo 2^CNT_WIDTH.

## Timing
- rd_en1/rd_en2 are combinational from current-cycle head inputs and state. The ROB advances its head at the same posedge.
- Head inputs reflect the new head the cycle after the pop.
- Commit records are registered: commitN_* valid in cycle T+1 for a pop in cycle T, held one cycle only. Payload fields are don't-care when valid=0.
- store_req rises the cycle after the decision. Minimum store retirement is 2 cycles after the store becomes done at the head, with ack in the first STORE_WAIT cycle.
- rob_flush rises the cycle after flush_req and stays high exactly FLUSH_CYCLES cycles.
- The first commit is possible in the cycle after rob_flush falls.
- Reset: state RUN, every output 0 (rd_en*, store_req, rob_flush, commit*, retired_count), flush counter 0. Reset mid-STORE_WAIT or mid-FLUSH aborts immediately.
- commit_stall gates pops the same cycle; it does not affect an in-progress STORE_WAIT or FLUSH.

## Test plan
- Both heads valid+done, non-store, pc 0x1000/0x1004 → rd_en1=rd_en2=1 same cycle; next cycle commit0_pc=0x1000, commit1_pc=0x1004, retired_count=2.
- head0 done, head1 not done → rd_en1=1 only, commit1_valid=0; head0 not done, head1 done → no pops, counter unchanged.
- head0 done store → store_req=1 next cycle; ack after 3 cycles → rd_en1=1 on ack cycle, rd_en2=0, store_req low next cycle, retired_count +1.
- flush_req while in STORE_WAIT with FLUSH_CYCLES=4 → no pop that cycle; store_req drops; rob_flush high exactly 4 cycles; commits resume in the cycle after rob_flush falls.
- commit_stall high for 5 cycles with both heads done → zero pops; on release, 2 pops in the first cycle.
- Preload retired_count=2^64-1, retire 2 → wraps to 1. Assert reset during FLUSH → all outputs 0 next cycle, state RUN.
